// File: rtl/prefetch_buffer_pkg.sv
// Shared definitions for the instruction prefetch buffer: FSM encoding and
// the fetch stride between consecutive instruction words.
package prefetch_buffer_pkg;

  typedef enum logic [1:0] {
    PF_IDLE    = 2'd0,
    PF_REQ     = 2'd1,
    PF_DISCARD = 2'd2
  } pf_state_t;

  localparam int unsigned WORD_STRIDE = 4;

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous FIFO holding fetched {instruction, address} entries; the head is
// read straight from storage, so a push is visible on the following cycle.
module prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_pop;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign do_pop = pop && !empty;
  assign head   = mem[rd_ptr];

  // clear wins over push and pop; pointers wrap naturally since DEPTH is 2^PW
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= din;
  end

  // the fetch FSM never starts a request unless a slot is free
  assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/prefetch_buffer.sv
// Instruction prefetch unit: keeps the FIFO topped up from instruction memory
// and absorbs redirects, draining any in-flight request without breaking valid/ready.
//
// imem handshake: imem_valid_o rises with imem_addr_o and both stay unchanged
// until the cycle imem_ready_i is seen high; that cycle completes the transfer
// and imem_rdata_i is taken then. instr side: an entry retires on
// instr_valid_o & instr_ready_i.
module prefetch_buffer
  import prefetch_buffer_pkg::*;
#(
  parameter int                    DEPTH        = 4,
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDRESS = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic [ADDR_WIDTH-1:0]      flush_addr_i,
  input  logic                       instr_ready_i,
  output logic                       instr_valid_o,
  output logic [DATA_WIDTH-1:0]      instr_o,
  output logic [ADDR_WIDTH-1:0]      instr_addr_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       imem_valid_o,
  input  logic                       imem_ready_i,
  output logic [ADDR_WIDTH-1:0]      imem_addr_o,
  output logic [3:0]                 imem_we_o,
  output logic [DATA_WIDTH-1:0]      imem_wdata_o,
  input  logic [DATA_WIDTH-1:0]      imem_rdata_i,
  output logic [1:0]                 state_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = DATA_WIDTH + ADDR_WIDTH;

  pf_state_t             state;
  pf_state_t             next_state;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] held_addr;
  logic                  push;
  logic                  pop;
  logic                  empty;
  logic                  full;
  logic [EW-1:0]         head;
  logic [CW:0]           count_after_push;

  assign pop              = instr_ready_i && !empty;
  assign count_after_push = {1'b0, count_o} + (CW+1)'(1) - (CW+1)'(pop);

  always_comb begin
    next_state   = state;
    push         = 1'b0;
    imem_valid_o = 1'b0;
    imem_addr_o  = fetch_pc;
    unique case (state)
      PF_IDLE: begin
        // a flush empties the FIFO, so a slot is always free afterwards
        if (flush_i || !full) next_state = PF_REQ;
      end
      PF_REQ: begin
        imem_valid_o = 1'b1;
        if (flush_i) begin
          next_state = imem_ready_i ? PF_REQ : PF_DISCARD;
        end else if (imem_ready_i) begin
          push       = 1'b1;
          next_state = (count_after_push < (CW+1)'(DEPTH)) ? PF_REQ : PF_IDLE;
        end
      end
      PF_DISCARD: begin
        // fetch_pc already points at the redirect target; keep the stale request stable
        imem_valid_o = 1'b1;
        imem_addr_o  = held_addr;
        if (imem_ready_i) next_state = PF_REQ;
      end
      default: next_state = PF_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= PF_IDLE;
      fetch_pc  <= BOOT_ADDRESS;
      held_addr <= BOOT_ADDRESS;
    end else begin
      state <= next_state;
      if (state == PF_REQ) held_addr <= fetch_pc;
      if (flush_i) begin
        fetch_pc <= {flush_addr_i[ADDR_WIDTH-1:2], 2'b00};
      end else if (push) begin
        fetch_pc <= fetch_pc + ADDR_WIDTH'(WORD_STRIDE);
      end
    end
  end

  prefetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (flush_i),
    .din   ({imem_rdata_i, fetch_pc}),
    .head  (head),
    .count (count_o),
    .empty (empty),
    .full  (full)
  );

  assign instr_valid_o = !empty;
  assign instr_o       = head[EW-1:ADDR_WIDTH];
  assign instr_addr_o  = head[ADDR_WIDTH-1:0];
  assign imem_we_o     = 4'b0000;
  assign imem_wdata_o  = '0;
  assign state_o       = state;

endmodule

// File: tb/tb_prefetch_buffer.sv
// Self-checking bench for prefetch_buffer: directed redirect/full/wrap/reset
// scenarios plus a randomised phase, all scored against a fetch-order model.
module tb_prefetch_buffer;

  localparam logic [31:0] BOOT = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] flush_addr;
  logic        instr_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_addr;
  logic [2:0]  count;
  logic        imem_valid;
  logic        imem_ready;
  logic [31:0] imem_addr;
  logic [3:0]  imem_we;
  logic [31:0] imem_wdata;
  logic [31:0] imem_rdata;
  logic [1:0]  state;

  int n_checks = 0;
  int n_fail   = 0;
  int req_count = 0;

  logic [63:0] exp_q[$];
  logic [31:0] model_pc;
  logic        model_discard;
  logic        prev_pending;
  logic [31:0] prev_addr;

  prefetch_buffer #(
    .DEPTH        (4),
    .ADDR_WIDTH   (32),
    .DATA_WIDTH   (32),
    .BOOT_ADDRESS (BOOT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush),
    .flush_addr_i  (flush_addr),
    .instr_ready_i (instr_ready),
    .instr_valid_o (instr_valid),
    .instr_o       (instr),
    .instr_addr_o  (instr_addr),
    .count_o       (count),
    .imem_valid_o  (imem_valid),
    .imem_ready_i  (imem_ready),
    .imem_addr_o   (imem_addr),
    .imem_we_o     (imem_we),
    .imem_wdata_o  (imem_wdata),
    .imem_rdata_i  (imem_rdata),
    .state_o       (state)
  );

  // clock / memory model
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_flush(input logic [31:0] a);
    flush      = 1'b1;
    flush_addr = a;
    step(1);
    flush      = 1'b0;
  endtask

  task automatic wait_count(input logic [2:0] target, input string tag);
    int i;
    i = 0;
    while (count !== target && i < 50) begin
      step(1);
      i++;
    end
    check(tag, count, target);
  endtask

  // scoreboard: expected entries are pushed when a real fetch completes and
  // popped when the consumer retires the head
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_pc      = BOOT;
      model_discard = 1'b0;
      prev_pending  = 1'b0;
      prev_addr     = '0;
    end else begin
      if (prev_pending) begin
        check("imem_valid_held", imem_valid, 1'b1);
        check("imem_addr_held", imem_addr, prev_addr);
      end
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) check("unexpected_pop", 1'b1, 1'b0);
        else check("head_entry", {instr, instr_addr}, exp_q.pop_front());
      end
      if (imem_valid && imem_ready) begin
        req_count++;
        if (!model_discard && !flush) begin
          check("imem_addr", imem_addr, model_pc);
          exp_q.push_back({mem_word(model_pc), model_pc});
          model_pc = model_pc + 32'd4;
        end
        model_discard = 1'b0;
      end
      if (flush) begin
        exp_q.delete();
        model_pc = {flush_addr[31:2], 2'b00};
        if (imem_valid && !imem_ready) model_discard = 1'b1;
      end
      prev_pending = imem_valid && !imem_ready;
      prev_addr    = imem_addr;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    rst         = 1'b1;
    flush       = 1'b0;
    flush_addr  = '0;
    instr_ready = 1'b0;
    imem_ready  = 1'b1;

    #12;
    check("rst_instr_valid", instr_valid, 1'b0);
    check("rst_imem_valid", imem_valid, 1'b0);
    check("rst_count", count, 3'd0);
    check("rst_imem_addr", imem_addr, BOOT);
    check("rst_state", state, 2'd0);
    check("imem_we", imem_we, 4'b0);
    check("imem_wdata", imem_wdata, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // fill from boot with no consumer
    wait_count(3'd4, "fill_count");
    check("fill_req_count", req_count, 4);
    check("fill_imem_idle", imem_valid, 1'b0);
    step(5);
    check("full_no_req", req_count, 4);
    check("full_head_addr", instr_addr, BOOT);

    // single pop while full refills exactly one slot
    base = req_count;
    instr_ready = 1'b1;
    step(1);
    instr_ready = 1'b0;
    step(6);
    check("refill_one_req", req_count - base, 1);
    check("refill_count", count, 3'd4);
    check("refill_idle", imem_valid, 1'b0);

    // zero-wait streaming with continuous consumer
    instr_ready = 1'b1;
    do_flush(32'h0000_0400);
    for (int i = 0; i < 12; i++) begin
      step(1);
      check("stream_count_le1", count <= 3'd1, 1'b1);
      check("stream_valid", instr_valid, 1'b1);
      check("stream_addr", instr_addr, 32'h400 + 32'(4 * i));
    end
    instr_ready = 1'b0;

    // redirect during a slow request: stale data must be discarded
    do_flush(32'h0000_1000);
    imem_ready = 1'b0;
    check("slow_req_valid", imem_valid, 1'b1);
    check("slow_req_addr", imem_addr, 32'h1000);
    step(1);
    do_flush(32'h0000_2002);
    check("discard_addr_0", imem_addr, 32'h1000);
    check("discard_valid", imem_valid, 1'b1);
    step(1);
    check("discard_addr_1", imem_addr, 32'h1000);
    imem_ready = 1'b1;
    step(1);
    imem_ready = 1'b0;
    check("redirect_addr", imem_addr, 32'h2000);
    check("redirect_valid", imem_valid, 1'b1);
    check("redirect_empty", instr_valid, 1'b0);
    imem_ready = 1'b1;
    step(1);
    check("redirect_head_valid", instr_valid, 1'b1);
    check("redirect_head_addr", instr_addr, 32'h2000);

    // flush coincident with ready and pop while holding two entries
    wait_count(3'd2, "pre_flush_count");
    flush       = 1'b1;
    flush_addr  = 32'h0000_5000;
    instr_ready = 1'b1;
    step(1);
    flush       = 1'b0;
    instr_ready = 1'b0;
    check("coinc_count", count, 3'd0);
    check("coinc_instr_valid", instr_valid, 1'b0);
    check("coinc_imem_valid", imem_valid, 1'b1);
    check("coinc_imem_addr", imem_addr, 32'h5000);

    // address wrap
    do_flush(32'hFFFF_FFFC);
    wait_count(3'd2, "wrap_count");
    check("wrap_head0", instr_addr, 32'hFFFF_FFFC);
    instr_ready = 1'b1;
    step(1);
    instr_ready = 1'b0;
    check("wrap_head1_valid", instr_valid, 1'b1);
    check("wrap_head1", instr_addr, 32'h0000_0000);

    // reset while a request is pending
    imem_ready = 1'b0;
    do_flush(32'h0000_0600);
    step(1);
    check("pending_before_rst", imem_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_imem_valid", imem_valid, 1'b0);
    check("midrst_count", count, 3'd0);
    check("midrst_instr_valid", instr_valid, 1'b0);
    check("midrst_imem_addr", imem_addr, BOOT);
    step(1);
    rst        = 1'b0;
    imem_ready = 1'b1;
    step(1);
    check("restart_valid", imem_valid, 1'b1);
    check("restart_addr", imem_addr, BOOT);

    // randomised traffic
    for (int i = 0; i < 300; i++) begin
      imem_ready  = 1'($urandom_range(0, 1));
      instr_ready = 1'($urandom_range(0, 1));
      flush       = ($urandom_range(0, 15) == 0);
      flush_addr  = $urandom;
      step(1);
    end
    flush      = 1'b0;
    imem_ready = 1'b0;
    step(1);
    check("rand_occupancy", 64'(exp_q.size()), 64'(count));
    instr_ready = 1'b1;
    step(8);
    check("drain_count", count, 3'd0);
    check("drain_queue", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prefetch_buffer.md
Name: prefetch_buffer

Overview:
- Parametrised instruction prefetch unit between the instruction memory interface and the decoder/controller; successor to the single-word fetch path.
- Keeps up to DEPTH fetched words in flight-free storage so the core can retire back-to-back, and absorbs redirects (branch/jump/exception/mret) by flushing.
- Handles redirects that arrive while a memory request is pending without violating the imem valid/ready handshake.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- ADDR_WIDTH, 32, instruction address width.
- DATA_WIDTH, 32, instruction word width.
- BOOT_ADDRESS, 32'h0, first fetch address after reset.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset, asynchronous, active-high.
- flush_i  in  1  redirect strobe (controller target_valid).
- flush_addr_i  in  ADDR_WIDTH  redirect target; bits [1:0] ignored (treated as 0).
- instr_ready_i  in  1  consumer retires the head entry (pop).
- instr_valid_o  out  1  FIFO head valid.
- instr_o  out  DATA_WIDTH  head instruction word.
- instr_addr_o  out  ADDR_WIDTH  head instruction address.
- count_o  out  $clog2(DEPTH+1)  current occupancy.
- imem_valid_o  out  1  memory request valid.
- imem_ready_i  in  1  memory completes request; rdata valid this cycle.
- imem_addr_o  out  ADDR_WIDTH  request address, word aligned.
- imem_we_o  out  4  tied 4'b0.
- imem_wdata_o  out  DATA_WIDTH  tied 0.
- imem_rdata_i  in  DATA_WIDTH  returned word.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, fetch_pc=BOOT_ADDRESS, FIFO pointers=0, count_o=0.
  - instr_valid_o=0, imem_valid_o=0, imem_addr_o=BOOT_ADDRESS.
  - Reset asserted mid-request drops the request; no handshake obligation survives reset.
- States:
  - IDLE:
    - if count<DEPTH -> REQ; stay otherwise.
    - flush_i updates fetch_pc and empties the FIFO.
  - REQ:
    - imem_valid_o=1, imem_addr_o=fetch_pc; valid and address held stable until imem_ready_i.
    - On ready without flush: push {rdata, fetch_pc}; fetch_pc+=4 (wraps mod 2^ADDR_WIDTH).
    - Next state is REQ if count after this edge <DEPTH, else IDLE.
  - DISCARD:
    - imem_valid_o=1, old address held.
    - On ready: data dropped, -> REQ with the redirected fetch_pc.
    - Further flush_i in DISCARD only updates fetch_pc.
- Flush:
  - FIFO emptied on the same edge (count_o=0, instr_valid_o=0 next cycle); fetch_pc<=flush_addr_i & ~3.
  - In REQ without ready: -> DISCARD.
  - In REQ with ready in the same cycle: returned word dropped, -> REQ at the flush address.
  - Flush has priority over push and pop in the same cycle.
- Throughput and latency:
  - Zero-wait memory sustains 1 word/cycle.
  - A pushed word is visible on instr_* the cycle after imem_ready_i (registered head, no bypass).
  - Flush -> first imem_valid_o at the new address on the next cycle from REQ/IDLE.
- FIFO:
  - Pop when instr_ready_i & instr_valid_o; pop on empty is ignored.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap mod DEPTH.
  - Requests are only started with count<DEPTH and at most one is outstanding, so overflow is impossible. Assert this in simulation.
- Outputs instr_o and instr_addr_o are don't-care while instr_valid_o=0.

Decomposition:
- Shared package/defines file:
  - state encoding constants: PF_IDLE, PF_REQ, PF_DISCARD.
  - word byte stride constant (4).
- One sub-module: prefetch_fifo.
  - Synchronous FIFO, DEPTH x (DATA_WIDTH+ADDR_WIDTH).
  - Signals: push, pop, clear, count, head, empty/full.
  - Async active-high reset.
- The state machine and fetch_pc stay in prefetch_buffer.

Test Plan:
- Reset release with ready always 1, BOOT_ADDRESS=0x100, instr_ready_i=0 -> requests at 0x100, 0x104, 0x108, 0x10C, then imem_valid_o=0 and count_o=4.
- Zero-wait memory, instr_ready_i=1 continuously -> instr_addr_o increments by 4 every cycle after the first; count_o stays ≤1.
- Memory ready delayed 3 cycles, flush_i to 0x2002 on cycle 1 of the wait -> imem_addr_o holds the old address until ready; that data never appears; next request is 0x2000; first instr_addr_o=0x2000.
- flush_i coincident with imem_ready_i and instr_ready_i, FIFO holding 2 entries -> count_o=0 next cycle, returned word dropped, next request at the flush address.
- FIFO full (count 4), single pop -> exactly one new request is issued; count returns to 4; no request while full.
- Address wrap: flush to 0xFFFFFFFC -> fetches 0xFFFFFFFC then 0x00000000. Assert rst mid-request -> imem_valid_o=0 immediately; restart at BOOT_ADDRESS.
